// File: rtl/iec_host_tx_if.sv
// Host-side byte handshake between a controller and the iec_host_tx bus talker.
interface iec_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_atn;
    logic       tx_eoi;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output tx_data, tx_atn, tx_eoi, tx_last, tx_valid,
        input  tx_ready, tx_done, tx_err, err_code, busy
    );

    modport slave (
        input  tx_data, tx_atn, tx_eoi, tx_last, tx_valid,
        output tx_ready, tx_done, tx_err, err_code, busy
    );
endinterface

// File: rtl/iec_host_tx.sv
// IEC serial bus talker: sends one byte per host request, optionally under ATN.
// Define IEC_HOST_EOI_EN to enable the EOI handshake before the last data byte.
module iec_host_tx #(
    parameter int TICK_NODEV = 1000,
    parameter int TICK_FRAME = 1000,
    parameter int TICK_BIT   = 60
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    iec_host_tx_if.slave host,
    output logic         iec_atn_o,
    output logic         iec_clk_o,
    output logic         iec_data_o,
    input  logic         iec_clk_i,
    input  logic         iec_data_i
);
    localparam logic [9:0] NODEV_LAST  = 10'(TICK_NODEV - 1);
    localparam logic [9:0] FRAME_LAST  = 10'(TICK_FRAME - 1);
    localparam logic [9:0] BIT_LAST    = 10'(TICK_BIT - 1);
    localparam logic [9:0] ATNREL_LAST = 10'd19;
    localparam logic [9:0] SYNC_SETTLE = 10'd2;

    typedef enum logic [3:0] {
        IDLE,
        ATN_WAIT,
        TALK_RDY,
        LSN_WAIT,
`ifdef IEC_HOST_EOI_EN
        EOI_WAIT,
        EOI_ACK,
`endif
        BIT_SETUP,
        BIT_VALID,
        FRAME_WAIT,
        HOLD,
        ATN_REL
    } state_t;

    state_t     r_state;
    logic [9:0] r_tick;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_atn;
    logic       r_last;
    logic       r_ready;
    logic       r_done;
    logic       r_err;
    logic [1:0] r_err_code;
    logic       r_busy;
    logic       r_atn_o;
    logic       r_clk_o;
    logic       r_data_o;
    logic       r_clk_s1;
    logic       r_clk_s2;
    logic       r_data_s1;
    logic       r_data_s2;
`ifdef IEC_HOST_EOI_EN
    logic       r_eoi;
`endif

    logic w_accept;
    logic w_data;
    logic w_unused;

    assign w_accept = host.tx_valid & r_ready;
    assign w_data   = r_data_s2;
`ifdef IEC_HOST_EOI_EN
    assign w_unused = r_clk_s2;
`else
    assign w_unused = r_clk_s2 ^ host.tx_eoi;
`endif

    assign host.tx_ready = r_ready;
    assign host.tx_done  = r_done;
    assign host.tx_err   = r_err;
    assign host.err_code = r_err_code;
    assign host.busy     = r_busy;
    assign iec_atn_o     = r_atn_o;
    assign iec_clk_o     = r_clk_o;
    assign iec_data_o    = r_data_o;

    // Bus lines are sampled only on timing ticks, so the sync delay is two ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else if (ce) begin
            r_clk_s1  <= iec_clk_i;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= iec_data_i;
            r_data_s2 <= r_data_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_atn      <= 1'b0;
            r_last     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_busy     <= 1'b0;
            r_atn_o    <= 1'b1;
            r_clk_o    <= 1'b1;
            r_data_o   <= 1'b1;
`ifdef IEC_HOST_EOI_EN
            r_eoi      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (ce && r_tick != '1) r_tick <= r_tick + 10'd1;

            case (r_state)
                IDLE, HOLD: begin
                    if (w_accept) begin
                        r_shift    <= host.tx_data;
                        r_atn      <= host.tx_atn;
                        r_last     <= host.tx_last;
`ifdef IEC_HOST_EOI_EN
                        r_eoi      <= host.tx_eoi;
`endif
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_err_code <= 2'b00;
                        r_tick     <= '0;
                        r_atn_o    <= ~host.tx_atn;
                        if (host.tx_atn && r_state == IDLE) begin
                            r_state <= ATN_WAIT;
                            r_clk_o <= 1'b0;
                        end else begin
                            r_state <= TALK_RDY;
                            r_clk_o <= 1'b1;
                        end
                    end
                end

                ATN_WAIT: begin
                    if (ce) begin
                        if (!w_data) begin
                            r_state <= TALK_RDY;
                            r_clk_o <= 1'b1;
                            r_tick  <= '0;
                        end else if (r_tick == NODEV_LAST) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'b01;
                            r_atn_o    <= 1'b1;
                            r_clk_o    <= 1'b1;
                            r_data_o   <= 1'b1;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_tick     <= '0;
                            r_state    <= IDLE;
                        end
                    end
                end

                TALK_RDY: begin
                    if (ce) begin
                        r_state <= LSN_WAIT;
                        r_tick  <= '0;
                    end
                end

                LSN_WAIT: begin
                    if (ce && w_data) begin
                        r_tick <= '0;
`ifdef IEC_HOST_EOI_EN
                        if (r_eoi && !r_atn) begin
                            r_state <= EOI_WAIT;
                        end else begin
                            r_state  <= BIT_SETUP;
                            r_clk_o  <= 1'b0;
                            r_data_o <= r_shift[0];
                            r_bit    <= '0;
                        end
`else
                        r_state  <= BIT_SETUP;
                        r_clk_o  <= 1'b0;
                        r_data_o <= r_shift[0];
                        r_bit    <= '0;
`endif
                    end
                end

`ifdef IEC_HOST_EOI_EN
                EOI_WAIT: begin
                    if (ce && !w_data) begin
                        r_state <= EOI_ACK;
                        r_tick  <= '0;
                    end
                end

                EOI_ACK: begin
                    if (ce && w_data) begin
                        r_state  <= BIT_SETUP;
                        r_clk_o  <= 1'b0;
                        r_data_o <= r_shift[0];
                        r_bit    <= '0;
                        r_tick   <= '0;
                    end
                end
`endif

                BIT_SETUP: begin
                    if (ce && r_tick == BIT_LAST) begin
                        r_state <= BIT_VALID;
                        r_clk_o <= 1'b1;
                        r_tick  <= '0;
                    end
                end

                // The shifter drops the sent bit so bit[1] is always the next one out.
                BIT_VALID: begin
                    if (ce && r_tick == BIT_LAST) begin
                        r_tick  <= '0;
                        r_clk_o <= 1'b0;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state  <= FRAME_WAIT;
                            r_data_o <= 1'b1;
                        end else begin
                            r_state  <= BIT_SETUP;
                            r_data_o <= r_shift[1];
                            r_shift  <= {1'b0, r_shift[7:1]};
                        end
                    end
                end

                // The first ticks still show our own last data bit through the synchronizer.
                FRAME_WAIT: begin
                    if (ce) begin
                        if (!w_data && r_tick >= SYNC_SETTLE) begin
                            r_done <= 1'b1;
                            r_tick <= '0;
                            if (!r_last) begin
                                r_state <= HOLD;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end else if (!r_atn_o) begin
                                r_state <= ATN_REL;
                            end else begin
                                r_state <= IDLE;
                                r_clk_o <= 1'b1;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else if (r_tick == FRAME_LAST) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'b10;
                            r_atn_o    <= 1'b1;
                            r_clk_o    <= 1'b1;
                            r_data_o   <= 1'b1;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_tick     <= '0;
                            r_state    <= IDLE;
                        end
                    end
                end

                ATN_REL: begin
                    if (ce && r_tick == ATNREL_LAST) begin
                        r_state <= IDLE;
                        r_atn_o <= 1'b1;
                        r_clk_o <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_tick  <= '0;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iec_host_tx.sv
// Directed bench for iec_host_tx with a behavioural IEC listener on the bus.
// Expectations for the EOI phase follow whether IEC_HOST_EOI_EN is defined.
module tb_iec_host_tx;
    localparam int L_IDLE = 0;
    localparam int L_HOLD = 1;
    localparam int L_RX   = 2;
    localparam int L_EOI  = 3;
    localparam int L_ACK  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b0;
    logic atnO;
    logic clkO;
    logic dataO;
    logic lsnData = 1'b1;
    wire  busData = dataO & lsnData;
    wire  busClk  = clkO;

    int testsRun    = 0;
    int testsFailed = 0;
    int ceEdges     = 0;
    int ceStart     = 0;

    bit       lsnEnable    = 1'b0;
    bit       lsnAck       = 1'b0;
    bit       eoiSeen      = 1'b0;
    bit       eoiDone      = 1'b0;
    bit       firstFall    = 1'b0;
    bit       clkFallInEoi = 1'b0;
    int       lsnState     = L_IDLE;
    int       lsnTimer     = 0;
    int       rxCount      = 0;
    logic [7:0] rxByte     = 8'h00;
    logic     prevClk      = 1'b1;
    logic     prevAtn      = 1'b1;

    iec_host_tx_if host ();

    iec_host_tx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .host      (host),
        .iec_atn_o (atnO),
        .iec_clk_o (clkO),
        .iec_data_o(dataO),
        .iec_clk_i (busClk),
        .iec_data_i(busData)
    );

    // 100 MHz clock with a timing enable on every other rising edge.
    always #5 clk = ~clk;
    initial forever @(negedge clk) ce = ~ce;
    always @(posedge clk) if (ce) ceEdges++;

    // Listener: holds DATA while busy, samples on CLK rise, acks frames and EOI.
    initial begin
        logic clkRise, clkFall, atnFall;
        forever begin
            @(negedge clk);
            clkRise = busClk && !prevClk;
            clkFall = !busClk && prevClk;
            atnFall = !atnO && prevAtn;
            prevClk = busClk;
            prevAtn = atnO;
            if (!reset_n) begin
                lsnState = L_IDLE;
                lsnData  = 1'b1;
                lsnTimer = 0;
                rxCount  = 0;
            end else if (atnFall && lsnEnable) begin
                lsnData  = 1'b0;
                lsnState = L_HOLD;
                lsnTimer = 0;
            end else begin
                case (lsnState)
                    L_HOLD: begin
                        if (busClk) begin
                            lsnTimer++;
                            if (lsnTimer >= 4) begin
                                lsnData   = 1'b1;
                                lsnState  = L_RX;
                                lsnTimer  = 0;
                                rxCount   = 0;
                                firstFall = 1'b0;
                                eoiDone   = 1'b0;
                            end
                        end else begin
                            lsnTimer = 0;
                        end
                    end
                    L_RX: begin
                        if (clkFall) firstFall = 1'b1;
                        if (clkRise && rxCount < 8) begin
                            rxByte = {busData, rxByte[7:1]};
                            rxCount++;
                        end else if (clkFall && rxCount == 8) begin
                            lsnState = L_ACK;
                            lsnTimer = 0;
                        end else if (rxCount == 0 && !firstFall && !eoiDone && busClk) begin
                            lsnTimer++;
                            if (lsnTimer >= 500) begin
                                lsnData  = 1'b0;
                                eoiSeen  = 1'b1;
                                lsnState = L_EOI;
                                lsnTimer = 0;
                            end
                        end
                    end
                    L_EOI: begin
                        if (clkFall) clkFallInEoi = 1'b1;
                        lsnTimer++;
                        if (lsnTimer >= 120) begin
                            lsnData  = 1'b1;
                            eoiDone  = 1'b1;
                            lsnState = L_RX;
                            lsnTimer = 0;
                        end
                    end
                    L_ACK: begin
                        lsnTimer++;
                        if (lsnTimer >= 10) begin
                            lsnTimer = 0;
                            if (lsnAck) begin
                                lsnData  = 1'b0;
                                lsnState = L_HOLD;
                            end else begin
                                lsnState = L_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        host.tx_valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic atn, input logic eoi,
                                 input logic last);
        int guard = 0;
        while (!host.tx_ready && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("readyBeforeSend", host.tx_ready, 1);
        host.tx_data  = d;
        host.tx_atn   = atn;
        host.tx_eoi   = eoi;
        host.tx_last  = last;
        host.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        host.tx_valid = 1'b0;
        ceStart = ceEdges;
    endtask

    task automatic waitDoneErr(input int maxCycles, output bit sawDone, output bit sawErr);
        sawDone = 1'b0;
        sawErr  = 1'b0;
        for (int i = 0; i < maxCycles && !sawDone && !sawErr; i++) begin
            @(posedge clk);
            #1;
            sawDone = host.tx_done;
            sawErr  = host.tx_err;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit sawDone, sawErr;
        int guard, doneCount;
        host.tx_data  = 8'h00;
        host.tx_atn   = 1'b0;
        host.tx_eoi   = 1'b0;
        host.tx_last  = 1'b0;
        host.tx_valid = 1'b0;

        // Reset state
        #12;
        checkOutput("resetLines", {atnO, clkO, dataO}, 3'b111);
        checkOutput("resetReady", host.tx_ready, 1);
        checkOutput("resetBusy", host.busy, 0);
        checkOutput("resetDone", host.tx_done, 0);
        checkOutput("resetErr", host.tx_err, 0);
        checkOutput("resetCode", host.err_code, 0);
        applyReset();

        // No device answers ATN
        lsnEnable = 1'b0;
        applyStimulus(8'h28, 1'b1, 1'b0, 1'b1);
        checkOutput("busyAfterAccept", host.busy, 1);
        checkOutput("readyLowAfterAccept", host.tx_ready, 0);
        checkOutput("atnLowInAtnWait", {atnO, clkO}, 2'b00);
        waitDoneErr(3000, sawDone, sawErr);
        checkOutput("noDevErr", sawErr, 1);
        checkOutput("noDevDone", sawDone, 0);
        checkOutput("noDevCode", host.err_code, 2'b01);
        checkOutput("noDevTicks", ceEdges - ceStart, 1000);
        checkOutput("noDevLines", {atnO, clkO, dataO}, 3'b111);
        checkOutput("noDevReady", host.tx_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("errPulseWidth", host.tx_err, 0);
        checkOutput("errCodeHeld", host.err_code, 2'b01);

        // ATN byte 0x28 with last, listener acks
        applyReset();
        lsnEnable = 1'b1;
        lsnAck    = 1'b1;
        applyStimulus(8'h28, 1'b1, 1'b0, 1'b1);
        waitDoneErr(6000, sawDone, sawErr);
        checkOutput("atnByteDone", sawDone, 1);
        checkOutput("atnByteErr", sawErr, 0);
        checkOutput("atnByteBits", rxByte, 8'h28);
        checkOutput("atnByteCount", rxCount, 8);
        ceStart = ceEdges;
        @(posedge clk);
        #1;
        checkOutput("donePulseWidth", host.tx_done, 0);
        checkOutput("atnHeldAfterDone", atnO, 0);
        guard = 0;
        while (!atnO && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("atnRelTicks", ceEdges - ceStart, 20);
        checkOutput("atnRelLines", {atnO, clkO, dataO}, 3'b111);
        checkOutput("atnRelIdle", {host.busy, host.tx_ready}, 2'b01);

        // Listener never acks the frame
        applyReset();
        lsnEnable = 1'b1;
        lsnAck    = 1'b0;
        applyStimulus(8'h96, 1'b1, 1'b0, 1'b1);
        guard = 0;
        while (!(rxCount == 8 && !clkO) && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("frameBits", rxByte, 8'h96);
        ceStart = ceEdges;
        waitDoneErr(2500, sawDone, sawErr);
        checkOutput("frameErr", sawErr, 1);
        checkOutput("frameCode", host.err_code, 2'b10);
        checkOutput("frameTicks", ceEdges - ceStart, 1000);
        checkOutput("frameLines", {atnO, clkO, dataO}, 3'b111);

        // Reset during BIT_VALID
        applyReset();
        lsnEnable = 1'b1;
        lsnAck    = 1'b1;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        guard = 0;
        while (!(rxCount == 3 && clkO) && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("reachedBitValid", {rxCount[1:0], clkO}, 3'b111);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abortLines", {atnO, clkO, dataO}, 3'b111);
        checkOutput("abortReady", host.tx_ready, 1);
        checkOutput("abortBusy", host.busy, 0);
        repeat (4) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (host.tx_done || host.tx_err) doneCount++;
        end
        checkOutput("abortNoPulse", doneCount, 0);

        // Back-to-back: ATN byte held, then data byte with EOI and last
        applyReset();
        lsnEnable = 1'b1;
        lsnAck    = 1'b1;
        applyStimulus(8'h28, 1'b1, 1'b0, 1'b0);
        waitDoneErr(6000, sawDone, sawErr);
        checkOutput("firstByteDone", sawDone, 1);
        @(posedge clk);
        #1;
        checkOutput("holdClkLow", clkO, 0);
        checkOutput("holdReady", host.tx_ready, 1);
        checkOutput("holdBusy", host.busy, 0);
        checkOutput("holdAtnKept", atnO, 0);
        eoiSeen      = 1'b0;
        clkFallInEoi = 1'b0;
        applyStimulus(8'h0D, 1'b0, 1'b1, 1'b1);
        checkOutput("atnReleasedForData", atnO, 1);
        checkOutput("secondBusy", host.busy, 1);
        waitDoneErr(8000, sawDone, sawErr);
        checkOutput("secondByteDone", sawDone, 1);
        checkOutput("secondByteBits", rxByte, 8'h0D);
`ifdef IEC_HOST_EOI_EN
        checkOutput("eoiPhase", eoiSeen, 1);
        checkOutput("noBitBeforeEoiRelease", clkFallInEoi, 0);
`else
        checkOutput("eoiPhase", eoiSeen, 0);
`endif
        @(posedge clk);
        #1;
        checkOutput("finalLines", {atnO, clkO, dataO}, 3'b111);
        checkOutput("finalReady", host.tx_ready, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/iec_host_tx.md
IEC_HOST_TX -- requirements
Module: iec_host_tx

Interface
REQ-001 Parameter TICK_NODEV, default 1000, ce ticks allowed for a listener to pull DATA low after ATN is asserted.
REQ-002 Parameter TICK_FRAME, default 1000, ce ticks allowed for the listener's frame acknowledge after bit 8.
REQ-003 Parameter TICK_BIT, default 60, ce ticks for each bit phase (setup and valid).
REQ-004 Ports: clk in 1 system clock; reset_n in 1 asynchronous active-low reset; ce in 1 1 MHz timing enable.
REQ-005 Ports: tx_data in 8 byte to send; tx_atn in 1 send under ATN; tx_eoi in 1 last data byte (EOI); tx_last in 1 release bus after this byte; tx_valid in 1 request; tx_ready out 1 can accept.
REQ-006 Ports: tx_done out 1 byte-acknowledged pulse; tx_err out 1 error pulse; err_code out 2 01 no device, 10 frame timeout; busy out 1 transfer in progress.
REQ-007 Ports: iec_atn_o, iec_clk_o, iec_data_o out 1 each, open-collector (1 = released); iec_clk_i, iec_data_i in 1 each, wired-AND bus state.

Function
REQ-008 Bus inputs pass through 2-flop synchronizers; all bus sampling and tick counting occur only on cycles with ce=1.
REQ-009 Accept when tx_valid&tx_ready; latch tx_data/atn/eoi/last; tx_ready deasserts the next cycle.
REQ-010 States: IDLE, ATN_WAIT, TALK_RDY, LSN_WAIT, EOI_WAIT, EOI_ACK, BIT_SETUP, BIT_VALID, FRAME_WAIT, HOLD, ATN_REL.
REQ-011 IDLE: lines released, tx_ready=1; on accept with tx_atn=1 -> ATN_WAIT (ATN low, CLK low), else -> TALK_RDY.
REQ-012 ATN_WAIT: if synced DATA low before TICK_NODEV ticks -> TALK_RDY; on expiry -> error 01.
REQ-013 TALK_RDY: release CLK for one tick -> LSN_WAIT; LSN_WAIT waits, no timeout, for DATA released.
REQ-014 LSN_WAIT exit: if latched eoi=1 and not atn -> EOI_WAIT, else -> BIT_SETUP with CLK low.
REQ-015 EOI_WAIT: CLK stays released until DATA goes low (listener EOI ack) -> EOI_ACK; EOI_ACK waits for DATA released -> BIT_SETUP.
REQ-016 Bits LSB first: BIT_SETUP CLK low, DATA = bit (1 released) for TICK_BIT ticks; BIT_VALID CLK released for TICK_BIT ticks; 3-bit counter, wraps 7->0 after bit 8.
REQ-017 After bit 8: CLK low, DATA released -> FRAME_WAIT; DATA low within TICK_FRAME ticks -> tx_done pulse one clk; expiry -> error 10.
REQ-018 After done: tx_last=0 -> HOLD (CLK low, ATN unchanged, tx_ready=1); accept in HOLD goes to TALK_RDY, with ATN asserted/kept if new tx_atn=1, ATN released first if it becomes 0.
REQ-019 After done with tx_last=1: if ATN asserted -> ATN_REL, hold 20 ticks, then release ATN and CLK -> IDLE; else release all -> IDLE.
REQ-020 Error: one-clk tx_err, err_code held until next accept, all lines released, -> IDLE same cycle.
REQ-021 busy=1 in every state except IDLE and HOLD.
REQ-022 Tick counter 10 bits, saturates; cleared on every state change.

Reset
REQ-023 reset_n low asynchronously forces IDLE, iec_atn_o/iec_clk_o/iec_data_o=1, tx_ready=1, tx_done=0, tx_err=0, err_code=00, busy=0, counters 0, synchronizers to 1.
REQ-024 Reset mid-transfer releases the bus immediately; the aborted byte is discarded, no done/err pulse.

Configuration
REQ-025 Macro IEC_HOST_EOI_EN: defined -> REQ-015 handshake applies; undefined -> tx_eoi ignored, EOI_WAIT/EOI_ACK removed, LSN_WAIT always exits to BIT_SETUP.

Verification
REQ-026 tx_atn=1, data 0x28, DATA never pulled -> tx_err, err_code=01 after 1000 ticks, all lines 1.
REQ-027 Listener model, tx_atn=1, tx_last=1, 0x28 -> DATA at CLK rising edges 0,0,0,1,0,1,0,0; tx_done; ATN released 20 ticks later.
REQ-028 With IEC_HOST_EOI_EN, tx_eoi=1, 0x0D, listener EOI-ack 60 ticks -> first BIT_SETUP only after DATA release; macro undefined -> no EOI phase.
REQ-029 Listener never acks frame -> err_code=10 1000 ticks after bit 8.
REQ-030 reset_n low during BIT_VALID -> lines released within the same cycle, tx_ready=1, no tx_done.
REQ-031 Two back-to-back bytes, first with tx_last=0 -> CLK low and tx_ready=1 in HOLD between them.
